// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath (master) drives the hazard-detection and exception inputs.
// The controller (slave) returns the stall/redirect and mult/div status.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [1:0]       id_tuse_rs;
  logic [1:0]       id_tuse_rt;
  logic             id_md_use;
  logic             id_eret;
  logic [4:0]       ex_wa;
  logic [1:0]       ex_tnew;
  logic [4:0]       mem_wa;
  logic [1:0]       mem_tnew;
  logic             ex_mtc0_epc;
  logic             mem_mtc0_epc;
  logic             md_start;
  logic             md_is_div;
  logic             int_req;

  logic             stall;
  logic             req;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;
  logic             in_handler;
  logic [7:0]       exc_count;

  modport master (
    output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use, id_eret,
           ex_wa, ex_tnew, mem_wa, mem_tnew, ex_mtc0_epc, mem_mtc0_epc,
           md_start, md_is_div, int_req,
    input  stall, req, md_busy, md_cnt, in_handler, exc_count
  );

  modport slave (
    input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use, id_eret,
           ex_wa, ex_tnew, mem_wa, mem_tnew, ex_mtc0_epc, mem_mtc0_epc,
           md_start, md_is_div, int_req,
    output stall, req, md_busy, md_cnt, in_handler, exc_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: data, mult/div and eret
// hazards, the mult/div busy counter, and the exception entry guard.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | normal execution; an int_req redirects fetch to the handler
// HANDLER | handler running; further requests held off until eret leaves ID
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  typedef enum logic {IDLE, HANDLER} state_t;

  state_t           state_q;
  logic             in_handler_q;
  logic [7:0]       exc_q;
  logic [CNT_W-1:0] cnt_q;

  logic haz_rs, haz_rt, haz_md, haz_eret;
  logic md_busy_c, req_c, stall_c, eret_exit;

  assign md_busy_c = (cnt_q != '0);

  // A source register stalls only if a producer ahead of it cannot deliver in time.
  always_comb begin
    haz_rs = (bus.id_rs != 5'd0) &&
             (((bus.ex_wa  == bus.id_rs) && (bus.ex_tnew  > bus.id_tuse_rs)) ||
              ((bus.mem_wa == bus.id_rs) && (bus.mem_tnew > bus.id_tuse_rs)));
    haz_rt = (bus.id_rt != 5'd0) &&
             (((bus.ex_wa  == bus.id_rt) && (bus.ex_tnew  > bus.id_tuse_rt)) ||
              ((bus.mem_wa == bus.id_rt) && (bus.mem_tnew > bus.id_tuse_rt)));
  end

  // Structural and EPC hazards, then combine; a handler redirect overrides any stall.
  always_comb begin
    haz_md    = bus.id_md_use && (md_busy_c || bus.md_start);
    haz_eret  = bus.id_eret && (bus.ex_mtc0_epc || bus.mem_mtc0_epc);
    req_c     = (state_q == IDLE) && bus.int_req;
    stall_c   = (haz_rs || haz_rt || haz_md || haz_eret) && !req_c;
    eret_exit = bus.id_eret && !stall_c;
  end

  // Busy counter: reload on an accepted issue, otherwise run down to zero.
  // A redirect does not abort an operation already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.md_start && !req_c) begin
      cnt_q <= bus.md_is_div ? DIV_LD : MULT_LD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Exception guard FSM; eret leaving ID takes priority over a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_handler_q <= 1'b0;
      exc_q        <= 8'd0;
    end else if (state_q == IDLE) begin
      if (bus.int_req) begin
        state_q      <= HANDLER;
        in_handler_q <= 1'b1;
        if (exc_q != 8'hFF) exc_q <= exc_q + 8'd1;
      end
    end else begin
      if (eret_exit) begin
        state_q      <= IDLE;
        in_handler_q <= 1'b0;
      end
    end
  end

  assign bus.stall      = stall_c;
  assign bus.req        = req_c;
  assign bus.md_busy    = md_busy_c;
  assign bus.md_cnt     = cnt_q;
  assign bus.in_handler = in_handler_q;
  assign bus.exc_count  = exc_q;

endmodule
